// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment rule that decides whether a request is rejected.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  // Halves need an even byte address, words a multiple of four; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bus bundles for the load/store unit: the core-facing request/response channel
// and the word-addressed data-memory port.
interface lsu_req_if #(parameter int DW = 32);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(parameter int DW = 32);
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extracts/extends load data from a memory word
// and merges sub-word store data into the previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] new_data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ld_data,
  output logic [31:0] mrg_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr_lo, 3'b000} +: 8];
  assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = word;
    case (size)
      SZ_B:    ld_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    ld_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_data = word;
    endcase
  end

  always_comb begin
    mrg_word = word;
    case (size)
      SZ_B:    mrg_word[{addr_lo, 3'b000} +: 8]    = new_data[7:0];
      SZ_H:    mrg_word[{addr_lo[1], 4'b0000} +: 16] = new_data[15:0];
      default: mrg_word = new_data;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: turns byte/half/word requests into word-indexed memory
// accesses, using read-modify-write for sub-word stores.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 121,
  parameter int DW        = 32
) (
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  localparam logic [DW-1:0] MEM_LIM = DW'(MEM_WORDS);

  state_t        state_q, state_d;
  logic          we_q, uns_q, err_q;
  logic [1:0]    size_q;
  logic [DW-1:0] addr_q, wdata_q, word_q;
  logic [DW-1:0] widx_q, ld_data, mrg_word;
  logic          accept, req_err;

  assign accept  = req.req_valid && (state_q == IDLE);
  assign req_err = (req.req_size == 2'b11)
                || is_misaligned(req.req_size, req.req_addr[1:0])
                || ({2'b00, req.req_addr[DW-1:2]} >= MEM_LIM);
  assign widx_q  = {2'b00, addr_q[DW-1:2]};

  always_comb begin
    state_d          = state_q;
    req.req_ready    = (state_q == IDLE) && !rst;
    req.resp_valid   = 1'b0;
    req.resp_err     = 1'b0;
    req.resp_rdata   = '0;
    mem.mem_we       = 1'b0;
    mem.mem_addr     = '0;
    mem.mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                              state_d = RESP;
          else if (req.req_we && req.req_size == SZ_W) state_d = WR;
          else                                      state_d = RD;
        end
      end
      RD: begin
        mem.mem_addr = widx_q;
        state_d      = we_q ? WR : RESP;
      end
      WR: begin
        // Gating with rst keeps a reset landing mid-RMW from committing a partial word.
        mem.mem_we    = !rst;
        mem.mem_addr  = widx_q;
        mem.mem_wdata = mrg_word;
        state_d       = RESP;
      end
      RESP: begin
        req.resp_valid = 1'b1;
        req.resp_err   = err_q;
        req.resp_rdata = (we_q || err_q) ? '0 : ld_data;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req.req_we;
        size_q  <= req.req_size;
        uns_q   <= req.req_unsigned;
        addr_q  <= req.req_addr;
        wdata_q <= req.req_wdata;
        err_q   <= req_err;
      end
      if (state_q == RD) word_q <= mem.mem_rdata;
    end
  end

  lsu_lane_align u_align (
    .word        (word_q),
    .new_data    (wdata_q),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ld_data     (ld_data),
    .mrg_word    (mrg_word)
  );

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural data memory and a response scoreboard.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lsu_req_if #(.DW(32)) req_bus ();
  lsu_mem_if #(.DW(32)) mem_bus ();

  lsu_ctrl #(.MEM_WORDS(121), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .req (req_bus.slave),
    .mem (mem_bus.master)
  );

  // Behavioural memory: combinational read, posedge write; preload port for setup.
  logic [31:0] mem [0:127];
  logic        pl_en = 1'b0;
  logic [6:0]  pl_addr = 7'd0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_bus.mem_we && mem_bus.mem_addr < 32'd128) mem[mem_bus.mem_addr[6:0]] <= mem_bus.mem_wdata;
  end

  assign mem_bus.mem_rdata = (mem_bus.mem_addr < 32'd128) ? mem[mem_bus.mem_addr[6:0]] : 32'h0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  int          we_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic        c1_we = 1'b0;
  logic [31:0] c1_addr = 32'h0;
  int          w0, r0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (mem_bus.mem_we) begin
      we_cnt++;
      wr_addr = mem_bus.mem_addr;
      wr_data = mem_bus.mem_wdata;
    end
    if (req_bus.resp_valid) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'(req_bus.resp_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("resp_err",   32'(req_bus.resp_err), 32'(e.err));
        chk("resp_rdata", req_bus.resp_rdata, e.rdata);
        chk("resp_lat",   cyc_n - e.acc + 1, e.lat);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    mon();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) cyc();
    if (sb.size() != 0) begin
      chk("resp_timeout", sb.size(), 32'h0);
      sb.delete();
    end
    cyc();
  endtask

  task automatic push(input logic err, input logic [31:0] rd, input int lat);
    exp_t e;
    e.err = err; e.rdata = rd; e.lat = lat; e.acc = cyc_n + 1;
    sb.push_back(e);
  endtask

  task automatic issue(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic e_err, input logic [31:0] e_rd, input int e_lat, input int e_wr);
    int wb;
    wb = we_cnt;
    req_bus.req_valid    = 1'b1;
    req_bus.req_we       = we;
    req_bus.req_size     = size;
    req_bus.req_unsigned = uns;
    req_bus.req_addr     = addr;
    req_bus.req_wdata    = wdata;
    #1;
    chk({tag, "_ready"}, 32'(req_bus.req_ready), 32'h1);
    push(e_err, e_rd, e_lat);
    cyc();
    c1_we   = mem_bus.mem_we;
    c1_addr = mem_bus.mem_addr;
    req_bus.req_valid = 1'b0;
    drain();
    chk({tag, "_writes"}, we_cnt - wb, e_wr);
  endtask

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    cyc();
    pl_en = 1'b0;
  endtask

  initial begin
    req_bus.req_valid    = 1'b0;
    req_bus.req_we       = 1'b0;
    req_bus.req_size     = 2'b00;
    req_bus.req_unsigned = 1'b0;
    req_bus.req_addr     = 32'h0;
    req_bus.req_wdata    = 32'h0;

    // Reset and memory preload
    rst = 1'b1;
    cyc();
    chk("rst_ready_low", 32'(req_bus.req_ready), 32'h0);
    preload(7'd5, 32'h8899AABB);
    preload(7'd4, 32'h11223344);
    preload(7'd2, 32'h00000000);
    rst = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(req_bus.resp_valid), 32'h0);
    chk("rst_resp_err",   32'(req_bus.resp_err), 32'h0);
    chk("rst_resp_rdata", req_bus.resp_rdata, 32'h0);
    chk("rst_mem_we",     32'(mem_bus.mem_we), 32'h0);
    chk("rst_mem_addr",   mem_bus.mem_addr, 32'h0);
    chk("rst_mem_wdata",  mem_bus.mem_wdata, 32'h0);
    chk("rst_ready_high", 32'(req_bus.req_ready), 32'h1);
    cyc();

    // Sub-word loads from word 5
    issue("lb_17",  1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 1'b0, 32'hFFFFFF88, 2, 0);
    issue("lbu_14", 1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 1'b0, 32'h000000BB, 2, 0);

    // Halfword store: read then write of word 5
    issue("sh_16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234, 1'b0, 32'h0, 3, 1);
    chk("sh_c1_we",   32'(c1_we), 32'h0);
    chk("sh_c1_addr", c1_addr, 32'h5);
    chk("sh_wr_addr", wr_addr, 32'h5);
    chk("sh_wr_data", wr_data, 32'h1234AABB);
    issue("lw_14",  1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'h1234AABB, 2, 0);
    issue("lh_14",  1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 1'b0, 32'hFFFFAABB, 2, 0);
    issue("lhu_16", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0, 32'h00001234, 2, 0);

    // Word store goes straight to WR
    issue("sw_08", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1);
    chk("sw_c1_we",   32'(c1_we), 32'h1);
    chk("sw_c1_addr", c1_addr, 32'h2);
    chk("sw_wr_data", wr_data, 32'hDEADBEEF);
    issue("lw_08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF, 2, 0);

    // Error cases
    issue("err_lw_15",  1'b0, 2'b10, 1'b0, 32'h15,  32'h0,        1'b1, 32'h0, 1, 0);
    issue("err_lh_13",  1'b0, 2'b01, 1'b0, 32'h13,  32'h0,        1'b1, 32'h0, 1, 0);
    issue("err_sw_1e4", 1'b1, 2'b10, 1'b0, 32'h1E4, 32'h12345678, 1'b1, 32'h0, 1, 0);
    issue("err_sz_11",  1'b0, 2'b11, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0, 1, 0);
    issue("ok_sw_1e0",  1'b1, 2'b10, 1'b0, 32'h1E0, 32'hCAFEF00D, 1'b0, 32'h0, 2, 1);
    chk("last_word_addr", wr_addr, 32'd120);

    // Reset during the WR cycle of a byte store
    r0 = resp_cnt;
    req_bus.req_valid = 1'b1;
    req_bus.req_we    = 1'b1;
    req_bus.req_size  = 2'b00;
    req_bus.req_unsigned = 1'b0;
    req_bus.req_addr  = 32'h10;
    req_bus.req_wdata = 32'h55;
    #1;
    chk("sb_ready", 32'(req_bus.req_ready), 32'h1);
    cyc();
    req_bus.req_valid = 1'b0;
    chk("sb_rd_we",   32'(mem_bus.mem_we), 32'h0);
    chk("sb_rd_addr", mem_bus.mem_addr, 32'h4);
    cyc();
    chk("sb_wr_addr", mem_bus.mem_addr, 32'h4);
    rst = 1'b1;
    #1;
    chk("sb_rst_we_gated", 32'(mem_bus.mem_we), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    chk("sb_rst_ready", 32'(req_bus.req_ready), 32'h1);
    chk("sb_word4_kept", mem[4], 32'h11223344);
    cyc();
    cyc();
    cyc();
    chk("sb_no_resp", resp_cnt - r0, 32'h0);

    // Back-to-back loads with req_valid held high
    r0 = resp_cnt;
    req_bus.req_valid = 1'b1;
    req_bus.req_we    = 1'b0;
    req_bus.req_size  = 2'b10;
    req_bus.req_addr  = 32'h14;
    #1;
    chk("b2b_ready_idle1", 32'(req_bus.req_ready), 32'h1);
    push(1'b0, 32'h1234AABB, 2);
    cyc();
    req_bus.req_addr = 32'h08;
    #1;
    chk("b2b_ready_rd", 32'(req_bus.req_ready), 32'h0);
    cyc();
    chk("b2b_ready_resp", 32'(req_bus.req_ready), 32'h0);
    cyc();
    chk("b2b_ready_idle2", 32'(req_bus.req_ready), 32'h1);
    push(1'b0, 32'hDEADBEEF, 2);
    cyc();
    req_bus.req_valid = 1'b0;
    drain();
    chk("b2b_resp_count", resp_cnt - r0, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=stalled expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the MIPS datapath and the word-addressed data memory (1 write port, 1 combinational read port, writes on posedge when WE).
- Accepts byte, halfword and word loads and stores at byte addresses.
- Converts each request into word-index memory accesses. Sub-word stores use read-modify-write.
- Returns sign- or zero-extended load data plus a single-cycle response pulse. The core stalls while req_ready=0.

Parameters:
- MEM_WORDS, 121, number of 32-bit words in the data memory; a word index >= MEM_WORDS is an error.
- DW, 32, data/address width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; equals (state==IDLE) && !rst.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  DW  byte address.
- req_wdata  in  DW  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DW  load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned, illegal size or out of range.
- mem_we  out  1  memory write enable.
- mem_addr  out  DW  word index = {2'b00, addr[31:2]}.
- mem_wdata  out  DW  full word to write.
- mem_rdata  in  DW  combinational read data at mem_addr.

Behaviour:
- Reset: state=IDLE, and all of the following are 0: resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata, and the latched request registers.
- rst takes priority over everything. If asserted in any state (including mid-RMW), the block returns to IDLE at that edge. mem_we is gated to 0 during any cycle with rst=1, so no partial write occurs.
- Accept: handshake occurs when req_valid && req_ready at a posedge. At that edge the block latches we, size, unsigned, addr and wdata, and checks for errors.
- Errors:
  - req_size==11.
  - Half access with addr[0]!=0.
  - Word access with addr[1:0]!=0.
  - addr[31:2] >= MEM_WORDS.
  - On any error: IDLE -> RESP, resp_err=1, no memory access (mem_we never asserted).
- States:
  - IDLE.
  - RD: mem_addr driven; mem_rdata captured into word_q at the edge leaving RD.
  - WR: mem_we=1, mem_addr and mem_wdata driven for exactly one cycle.
  - RESP: resp_valid=1 for one cycle, then IDLE.
- Transitions from IDLE on accept:
  - Load: RD -> RESP.
  - Word store: WR -> RESP.
  - Byte/half store: RD -> WR -> RESP.
  - Error: RESP.
- Latency, accept edge to resp_valid high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- mem_addr holds the latched word index in RD and WR, and is 0 otherwise. mem_wdata is 0 outside WR.
- Lanes are little-endian.
  - Byte lane k = addr[1:0], bits [8k+7:8k].
  - Half lane h = addr[1], bits [16h+15:16h].
- Load extension: sign-extend from bit 7 (byte) or bit 15 (half) unless unsigned; word loads pass through unchanged.
- Store merge: the replaced lane is taken from req_wdata[7:0] or [15:0]; all other bits come from word_q.
- No response backpressure. A new request is accepted only in IDLE, i.e. the cycle after RESP at the earliest. req_valid in other states is ignored and not queued.

Decomposition:
- Shared package lsu_pkg:
  - size_t enum {SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10}.
  - state_t enum {IDLE, RD, WR, RESP}.
  - Function is_misaligned(size, addr[1:0]).
- Sub-module lsu_lane_align, combinational:
  - Extract path: word, addr[1:0], size, unsigned -> extended load data.
  - Merge path: old word, new data, addr[1:0], size -> merged word.

Test Plan:
- Memory word 5 = 0x8899AABB.
  - LB at addr 0x17 -> resp_rdata=0xFFFFFF88, resp_err=0, 2 cycles, mem_we never high.
  - LBU at addr 0x14 -> resp_rdata=0x000000BB.
- SH 0x00001234 at addr 0x16 (word 5 = 0x8899AABB):
  - Sequence is RD then WR, mem_addr=5, mem_wdata=0x1234AABB.
  - Subsequent LW 0x14 returns 0x1234AABB.
- SW 0xDEADBEEF at addr 0x08 -> WR in cycle 1 with mem_addr=2, resp_valid in cycle 2; LW 0x08 returns 0xDEADBEEF.
- Error cases, each giving resp_err=1 one cycle after accept, resp_rdata=0 and mem_we=0 throughout:
  - LW at 0x15.
  - LH at 0x13.
  - SW at 0x1E4 (word 121).
  - req_size=11.
- Reset mid-operation: issue SB 0x55 at 0x10, assert rst during the WR cycle.
  - Required: mem_we=0 in that cycle and memory word 4 unchanged.
  - Next cycle: IDLE, req_ready=1, resp_valid never pulses.
- Back-to-back: hold req_valid=1 with two LWs.
  - Second is accepted only in the cycle after RESP; req_ready=0 in RD and RESP.
